// File: rtl/modn_updown_counter_if.sv
// Control/status bundle for modn_updown_counter: master drives the controls, slave is the counter.
// wrap_cnt and its width parameter exist only when MODN_WRAP_CNT_EN is defined.
interface modn_updown_counter_if #(
  parameter int WIDTH = 4
`ifdef MODN_WRAP_CNT_EN
  , parameter int WRAP_CNT_W = 8
`endif
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] term_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] term;
  logic             tc;
  logic             wrap;
  logic             load_err;
`ifdef MODN_WRAP_CNT_EN
  logic [WRAP_CNT_W-1:0] wrap_cnt;

  modport master (output en, up_dn, load, load_val, term_in,
                  input  q, term, tc, wrap, load_err, wrap_cnt);
  modport slave  (input  en, up_dn, load, load_val, term_in,
                  output q, term, tc, wrap, load_err, wrap_cnt);
`else
  modport master (output en, up_dn, load, load_val, term_in,
                  input  q, term, tc, wrap, load_err);
  modport slave  (input  en, up_dn, load, load_val, term_in,
                  output q, term, tc, wrap, load_err);
`endif
endinterface

// File: rtl/modn_updown_counter.sv
// Run-time programmable modulo-M up/down counter with load, cascade tc and wrap pulse.
// Define MODN_WRAP_CNT_EN to add the saturating wrap_cnt output.
module modn_updown_counter #(
  parameter int WIDTH      = 4,
  parameter int RST_TERM   = 5,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  modn_updown_counter_if.slave bus
);

  if (RST_TERM < 1 || RST_TERM >= (1 << WIDTH)) begin : g_bad_rst_term
    $error("RST_TERM must lie in 1..2**WIDTH-1");
  end
  if (WRAP_CNT_W < 1) begin : g_bad_wrap_cnt_w
    $error("WRAP_CNT_W must be at least 1");
  end

  localparam logic [WIDTH-1:0] RST_TERM_V = WIDTH'(RST_TERM);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic [WIDTH-1:0] term_in_s;
  logic             wrap_edge;

  // A requested terminal of 0 would make a mod-1 counter; it is promoted to 1.
  assign term_in_s = (bus.term_in == '0) ? WIDTH'(1) : bus.term_in;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    q_d        = q_q;
    term_d     = term_q;
    load_err_d = 1'b0;
    wrap_edge  = 1'b0;
    if (bus.load) begin
      term_d = term_in_s;
      if (bus.load_val <= term_in_s) begin
        q_d = bus.load_val;
      end else begin
        q_d        = '0;
        load_err_d = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (q_q == term_q) begin
          q_d       = '0;
          wrap_edge = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
          // Down-wrap lands on the freshly requested terminal, not the old one.
          q_d       = term_in_s;
          wrap_edge = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
      if (wrap_edge) term_d = term_in_s;
    end
    wrap_d = wrap_edge;
  end

  // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q        <= '0;
      term_q     <= RST_TERM_V;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      term_q     <= term_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.term     = term_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;
  assign bus.tc       = bus.en & (bus.up_dn ? (q_q == term_q) : (q_q == '0));

`ifdef MODN_WRAP_CNT_EN
  logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

  // Saturates at all-ones; only rst_n clears it.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (wrap_edge && (wrap_cnt_q != '1)) wrap_cnt_d = wrap_cnt_q + WRAP_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap_cnt_q <= '0;
    else        wrap_cnt_q <= wrap_cnt_d;
  end

  assign bus.wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_modn_updown_counter.sv
// Self-checking bench for modn_updown_counter: arithmetic reference model compared every
// falling edge, directed sequences with literal expectations, and a two-stage cascade.
module tb_modn_updown_counter;
  localparam int W        = 4;
  localparam int RST_TERM = 5;
  localparam int WC_MAX   = 255;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  modn_updown_counter_if #(.WIDTH(W)) bus  ();
  modn_updown_counter_if #(.WIDTH(W)) cas1 ();
  modn_updown_counter_if #(.WIDTH(W)) cas2 ();

  modn_updown_counter #(.WIDTH(W), .RST_TERM(RST_TERM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  modn_updown_counter #(.WIDTH(W), .RST_TERM(RST_TERM)) st1 (.clk(clk), .rst_n(rst_n), .bus(cas1));
  modn_updown_counter #(.WIDTH(W), .RST_TERM(RST_TERM)) st2 (.clk(clk), .rst_n(rst_n), .bus(cas2));

  assign cas2.en = cas1.tc;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the counting rules.
  int m_q    = 0;
  int m_term = RST_TERM;
  bit m_wrap = 1'b0;
  bit m_err  = 1'b0;
  int m_wcnt = 0;

  function automatic int sanitize(input int t);
    return (t == 0) ? 1 : t;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= 0; m_term <= RST_TERM; m_wrap <= 1'b0; m_err <= 1'b0; m_wcnt <= 0;
    end else begin
      m_wrap <= 1'b0;
      m_err  <= 1'b0;
      if (bus.load) begin
        m_term <= sanitize(int'(bus.term_in));
        if (int'(bus.load_val) > sanitize(int'(bus.term_in))) begin
          m_q <= 0; m_err <= 1'b1;
        end else begin
          m_q <= int'(bus.load_val);
        end
      end else if (bus.en) begin
        if (bus.up_dn) begin
          m_q <= (m_q + 1) % (m_term + 1);
          if (m_q == m_term) begin
            m_wrap <= 1'b1; m_term <= sanitize(int'(bus.term_in));
            if (m_wcnt < WC_MAX) m_wcnt <= m_wcnt + 1;
          end
        end else if (m_q == 0) begin
          m_q <= sanitize(int'(bus.term_in)); m_term <= sanitize(int'(bus.term_in));
          m_wrap <= 1'b1;
          if (m_wcnt < WC_MAX) m_wcnt <= m_wcnt + 1;
        end else begin
          m_q <= m_q - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_q",        bus.q,        m_q);
    check("cmp_term",     bus.term,     m_term);
    check("cmp_wrap",     bus.wrap,     m_wrap);
    check("cmp_load_err", bus.load_err, m_err);
    check("cmp_tc",       bus.tc,       bus.en && (bus.up_dn ? (m_q == m_term) : (m_q == 0)));
    check("cmp_inv",      bus.q <= bus.term, 1);
`ifdef MODN_WRAP_CNT_EN
    check("cmp_wrap_cnt", bus.wrap_cnt, m_wcnt);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit en, input bit up, input bit ld, input int lv, input int ti);
    bus.en = en; bus.up_dn = up; bus.load = ld;
    bus.load_val = W'(lv); bus.term_in = W'(ti);
  endtask

  int exp1 [14] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0, 1, 2};
  int exp2 [7]  = '{5, 4, 3, 2, 1, 0, 5};
  int exp2w[7]  = '{1, 0, 0, 0, 0, 0, 1};
  int exp3 [14] = '{3, 4, 5, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0};

  initial begin
    drive(0, 1, 0, 0, 5);
    cas1.en = 1'b0; cas1.up_dn = 1'b1; cas1.load = 1'b0; cas1.load_val = '0; cas1.term_in = 4'd5;
    cas2.up_dn = 1'b1; cas2.load = 1'b0; cas2.load_val = '0; cas2.term_in = 4'd5;
    #1 rst_n = 1'b0;
    #2;
    check("rst_q", bus.q, 0);
    check("rst_term", bus.term, 5);
    check("rst_wrap", bus.wrap, 0);
    check("rst_load_err", bus.load_err, 0);
    #9 rst_n = 1'b1;
    tick();
    check("idle_q", bus.q, 0);

    // 1: default mod-6 up count
    drive(1, 1, 0, 0, 5);
    for (int k = 0; k < 14; k++) begin
      tick();
      check("t1_q", bus.q, exp1[k]);
      check("t1_wrap", bus.wrap, exp1[k] == 0);
      check("t1_tc", bus.tc, exp1[k] == 5);
    end

    // 2: down count from 0
    drive(0, 1, 1, 0, 5);
    tick();
    check("t2_load_q", bus.q, 0);
    drive(1, 0, 0, 0, 5);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("t2_q", bus.q, exp2[k]);
      check("t2_wrap", bus.wrap, exp2w[k]);
      check("t2_tc", bus.tc, exp2[k] == 0);
    end

    // 3: terminal change mid-cycle takes effect only after the wrap
    drive(0, 1, 1, 2, 5);
    tick();
    drive(1, 1, 0, 0, 9);
    for (int k = 0; k < 14; k++) begin
      tick();
      check("t3_q", bus.q, exp3[k]);
      check("t3_term", bus.term, (k < 3) ? 5 : 9);
    end

    // 4: load in range, load clamped, load error pulse
    drive(1, 1, 1, 3, 7);
    tick();
    check("t4_q", bus.q, 3);
    check("t4_term", bus.term, 7);
    check("t4_wrap", bus.wrap, 0);
    check("t4_err", bus.load_err, 0);
    drive(1, 1, 1, 12, 7);
    tick();
    check("t4_clamp_q", bus.q, 0);
    check("t4_clamp_err", bus.load_err, 1);
    drive(0, 0, 0, 0, 7);
    #1 check("t4_tc_dis", bus.tc, 0);
    tick();
    check("t4_hold_q", bus.q, 0);
    check("t4_err_pulse", bus.load_err, 0);

    // term_in == 0 is treated as 1
    drive(0, 1, 1, 1, 0);
    tick();
    check("t0_term", bus.term, 1);
    check("t0_q", bus.q, 1);
    check("t0_err", bus.load_err, 0);
    drive(0, 1, 1, 2, 0);
    tick();
    check("t0_clamp_q", bus.q, 0);
    check("t0_clamp_err", bus.load_err, 1);

    // down-wrap reloads with the new term_in, then direction changes
    drive(0, 1, 1, 0, 5);
    tick();
    drive(1, 0, 0, 0, 3);
    tick();
    check("dw_q", bus.q, 3);
    check("dw_term", bus.term, 3);
    check("dw_wrap", bus.wrap, 1);
    tick();
    check("dir_dn_q", bus.q, 2);
    drive(1, 1, 0, 0, 3);
    tick();
    check("dir_up_q", bus.q, 3);
    check("dir_up_wrap", bus.wrap, 0);
    drive(1, 0, 0, 0, 3);
    tick();
    check("dir_dn2_q", bus.q, 2);
    check("dir_dn2_wrap", bus.wrap, 0);

    // full binary range
    drive(1, 1, 1, 14, 15);
    tick();
    check("fb_q14", bus.q, 14);
    check("fb_term", bus.term, 15);
    drive(1, 1, 0, 0, 15);
    tick();
    check("fb_q15", bus.q, 15);
    tick();
    check("fb_q0", bus.q, 0);
    check("fb_wrap", bus.wrap, 1);

    // 5: asynchronous reset mid-count
    drive(0, 1, 1, 0, 5);
    tick();
    drive(1, 1, 0, 0, 5);
    repeat (4) tick();
    check("t5_pre_q", bus.q, 4);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_q", bus.q, 0);
    check("t5_rst_term", bus.term, 5);
    check("t5_rst_wrap", bus.wrap, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("t5_resume_q", bus.q, 1);

    // 6: two-stage cascade, both mod-6
    bus.en = 1'b0;
    cas1.load = 1'b1; cas2.load = 1'b1;
    tick();
    cas1.load = 1'b0; cas2.load = 1'b0;
    check("t6_init1", cas1.q, 0);
    check("t6_init2", cas2.q, 0);
    cas1.en = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      tick();
      check("t6_s1_q", cas1.q, k % 6);
      check("t6_s2_q", cas2.q, (k / 6) % 6);
      if (k == 6) check("t6_s2_first", cas2.q, 1);
    end
    check("t6_end1", cas1.q, 0);
    check("t6_end2", cas2.q, 0);
`ifdef MODN_WRAP_CNT_EN
    check("t6_wrap_cnt1", cas1.wrap_cnt, 6);
    check("t6_wrap_cnt2", cas2.wrap_cnt, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
